// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch controller feeding a UART transmitter: bytes queue up from a
// producer and are launched one at a time, paced by the transmitter's busy/done outputs.
module uart_tx_feeder #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              tx_en,
  input  logic              clr_err,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              timeout_err,
  output logic              sending,
  output logic [1:0]        state_dbg
);

  // Handshake: a byte is accepted on every edge where wr_en=1 and full=0 (full acts as
  // the inverse of ready); wr_en=1 with full=1 drops the byte and raises overflow.
  // Downstream, tx_start is a one-cycle strobe qualifying tx_data.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int TIMER_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);
  localparam logic [ADDR_W:0]    COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]    COUNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0]  PTR_ONE    = ADDR_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [TIMER_W-1:0]  timer;
  logic                launch;
  logic                timer_inc;
  logic                timeout_hit;
  logic                push;
  logic                drop;

  assign full      = (count == COUNT_FULL);
  assign empty     = (count == '0);
  assign sending   = (state != IDLE);
  assign state_dbg = state;

  // Full is judged on the pre-edge count, so a pop in the same cycle does not make room.
  assign push = wr_en && !full;
  assign drop = wr_en && full;

  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    timer_inc   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (tx_en && !empty && !tx_busy) begin
          launch    = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (timer == TIMER_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        // Busy dropping without a done pulse also ends the byte.
        if (tx_done || !tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      timer       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_start <= launch;
      if (launch) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
        timer   <= '0;
      end else if (timer_inc) begin
        timer <= timer + TIMER_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      case ({push, launch})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      // A new error event outranks a clear in the same cycle.
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte buffer and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from a producer (button/FSM/loopback logic) into a circular FIFO, then drives the transmitter's start/data inputs one byte at a time. It paces each launch on the transmitter's busy and done outputs, so producers can burst bytes without tracking line timing.

Parameters:
DEPTH, 16, FIFO entries; power of two, ≥2
ADDR_W, 4, log2(DEPTH)
BUSY_TIMEOUT, 4, max cycles in WAIT_BUSY before abandoning a launch

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  push request, one byte per cycle
wr_data  in  8  byte to push
tx_en  in  1  1 = launches allowed; 0 = pause after current byte
clr_err  in  1  clears sticky error flags
tx_busy  in  1  from transmitter busy output
tx_done  in  1  from transmitter done pulse
tx_start  out  1  one-cycle launch pulse to transmitter start
tx_data  out  8  byte to transmitter data input, valid while tx_start=1
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  ADDR_W+1  stored bytes, 0..DEPTH
overflow  out  1  sticky: push attempted while full
timeout_err  out  1  sticky: launch not acknowledged by tx_busy
sending  out  1  state != IDLE

Behaviour:
- Reset (clk edge with rst=1): wr_ptr=rd_ptr=0, count=0, state=IDLE, tx_start=0, tx_data=0, overflow=0, timeout_err=0. Outputs: empty=1, full=0, sending=0. Reset mid-transfer discards all stored bytes and any byte in flight.
- All outputs are registered or decoded directly from registered count/state.
- Push: wr_en=1 and full=0 → mem[wr_ptr]=wr_data; wr_ptr wraps DEPTH-1→0; count+1.
- wr_en=1 while full=1 → byte dropped, overflow=1. This applies even if a pop occurs in the same cycle, because full is judged on the pre-edge count.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_en=1, empty=0 and tx_busy=0 at the edge: tx_start←1, tx_data←mem[rd_ptr], rd_ptr+1 (wraps), count-1, timer←0, state←WAIT_BUSY.
  - Otherwise tx_start←0.
- WAIT_BUSY:
  - tx_start is high only on the first cycle of this state; tx_start←0 at the next edge.
  - tx_busy=1 → state←WAIT_DONE.
  - Else timer+1; when timer reaches BUSY_TIMEOUT-1 without busy → timeout_err=1, state←IDLE. The byte is counted as consumed and is not retried.
- WAIT_DONE:
  - tx_done=1 → state←IDLE.
  - tx_busy falling without tx_done → also IDLE.
- Launch spacing: the earliest next tx_start is 2 cycles after the tx_done cycle (done edge → IDLE, IDLE edge → start).
- tx_data holds its value until the next launch.
- tx_en=0 never aborts an in-flight byte; it only blocks the IDLE→WAIT_BUSY transition.
- clr_err=1 clears overflow and timeout_err at the edge. A new error event in the same cycle wins (flag stays 1).
- Latency: a push into an empty FIFO with the transmitter idle and tx_en=1 → tx_start high 2 cycles after the wr_en edge.

Test Plan:
- Reset, then push 0x55 with tx_en=1, using the real transmitter model → tx_start pulses once 2 cycles later with tx_data=0x55; count goes 1→0; sending=1 until the cycle after tx_done.
- Burst-push 0x01..0x05 on consecutive cycles → exactly 5 tx_start pulses in order 0x01..0x05, each only after the prior tx_done; count peaks at 4 or 5 and returns to 0; empty=1 at end.
- Push 17 bytes with tx_en=0 (DEPTH=16) → full=1 at count=16, overflow=1, byte 17 absent. Then tx_en=1 → bytes 1..16 sent in order, and pointers wrap correctly on a further push of 0xAA.
- tx_busy tied 0 with one byte pushed → tx_start pulses once, timeout_err=1 after BUSY_TIMEOUT cycles, FSM back in IDLE, count=0. Then clr_err → timeout_err=0.
- Assert rst during WAIT_DONE with 3 bytes queued → next cycle count=0, empty=1, tx_start=0, sending=0, and no further launches.
- Push and pop in the same cycle at count=16 (full) → push rejected, overflow=1, count=15 after the edge.
